// File: rtl/div_shift_scaler_ctrl.sv
// Sequenced shift-add constant scaler for the adaptive-filter step-size path.
// One operand per transaction. The product is built as a signed sum/difference of
// up to NTERM arithmetic right-shifts of the operand, one term per clock, through a
// single shared shifter/adder. The result is saturated to DW bits.
module div_shift_scaler_ctrl #(
    parameter int DW    = 33,
    parameter int NTERM = 4,
    parameter int SW    = 5
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_idx,
    input  logic [SW-1:0] cfg_shift,
    input  logic          cfg_en,
    input  logic          cfg_sub,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_sat,
    output logic          busy
);

    localparam int AW = DW + 3;
    localparam int CW = (NTERM > 1) ? $clog2(NTERM) : 1;
    localparam logic [CW-1:0]        LAST    = CW'(NTERM - 1);
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    // Reset coefficient 0.40625 = 2^-2 + 2^-3 + 2^-5
    function automatic logic [SW-1:0] dflt_shift(input int unsigned i);
        logic [SW-1:0] s;
        s = '0;
        if (i == 0) s = SW'(2);
        if (i == 1) s = SW'(3);
        if (i == 2) s = SW'(5);
        return s;
    endfunction

    state_t state, state_nxt;
    logic   alive;
    logic   accept;

    logic [SW-1:0] cfg_shift_r [NTERM];
    logic          cfg_en_r    [NTERM];
    logic          cfg_sub_r   [NTERM];
    logic [SW-1:0] snap_shift  [NTERM];
    logic          snap_en     [NTERM];
    logic          snap_sub    [NTERM];

    logic signed [DW-1:0] operand;
    logic signed [DW-1:0] shifted;
    logic signed [AW-1:0] term;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_nxt;
    logic [CW-1:0]        cnt;
    logic [DW-1:0]        res_data;
    logic                 res_sat;

    // Term-configuration bank, writable in any state
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NTERM; i++) begin
                cfg_shift_r[i] <= dflt_shift(i);
                cfg_en_r[i]    <= (i < 3);
                cfg_sub_r[i]   <= 1'b0;
            end
        end else if (cfg_we) begin
            cfg_shift_r[cfg_idx] <= cfg_shift;
            cfg_en_r[cfg_idx]    <= cfg_en;
            cfg_sub_r[cfg_idx]   <= cfg_sub;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and handshake outputs; alive keeps in_ready low while in reset
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = alive;
                if (in_valid && alive) begin
                    accept    = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shared shifter/adder for the current term, plus saturation of the running sum
    always_comb begin
        shifted  = operand >>> snap_shift[cnt];
        term     = {{(AW-DW){shifted[DW-1]}}, shifted};
        acc_nxt  = acc;
        if (snap_en[cnt]) acc_nxt = snap_sub[cnt] ? (acc - term) : (acc + term);
        res_sat  = 1'b0;
        res_data = acc_nxt[DW-1:0];
        if (acc_nxt > SAT_MAX) begin
            res_sat  = 1'b1;
            res_data = SAT_MAX[DW-1:0];
        end else if (acc_nxt < SAT_MIN) begin
            res_sat  = 1'b1;
            res_data = SAT_MIN[DW-1:0];
        end
    end

    // Operand capture, config snapshot, accumulation and result register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            alive    <= 1'b0;
            operand  <= '0;
            acc      <= '0;
            cnt      <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
            for (int unsigned i = 0; i < NTERM; i++) begin
                snap_shift[i] <= '0;
                snap_en[i]    <= 1'b0;
                snap_sub[i]   <= 1'b0;
            end
        end else begin
            alive <= 1'b1;
            if (accept) begin
                operand    <= in_data;
                acc        <= '0;
                cnt        <= '0;
                snap_shift <= cfg_shift_r;
                snap_en    <= cfg_en_r;
                snap_sub   <= cfg_sub_r;
            end else if (state == ACCUM) begin
                acc <= acc_nxt;
                cnt <= cnt + 1'b1;
                if (cnt == LAST) begin
                    out_data <= res_data;
                    out_sat  <= res_sat;
                end
            end
        end
    end

endmodule
